stage40: RTL and testbench

Output stage of the router pipeline, directly downstream of stage30. Buffers the system flits and normal flits that stage30 produces in the same cycle, arbitrates between them, and presents one flit per cycle to the link transmitter through a valid/ready handshake. Back-pressure from the link reaches stage30 and the earlier stages through `out_stall`.

---
 rtl/stage40.sv | 128 ++++++++++++
 tb/tb_stage40.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stage40.sv
// stage40: router output stage with sys/normal class FIFOs, a one-entry output register and link handshake.
// Optional macro STAGE40_ROUND_ROBIN_EN selects round-robin between contested classes instead of strict sys priority.
package types;
  typedef logic [15:0] flit_t;
endpackage

module stage40 #(
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          nocclk,
  input  logic          rst,
  input  logic          in_sys_flit_valid,
  input  types::flit_t  in_sys_flit,
  input  logic          in_normal_flit_valid,
  input  types::flit_t  in_normal_flit,
  output logic          out_stall,
  output logic          out_flit_valid,
  output types::flit_t  out_flit,
  input  logic          in_flit_ready,
  output logic [LW-1:0] out_sys_level,
  output logic [LW-1:0] out_normal_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL_CNT = LW'(FIFO_DEPTH);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  types::flit_t  sys_mem_p0 [FIFO_DEPTH];
  types::flit_t  nrm_mem_p0 [FIFO_DEPTH];
  logic [PW-1:0] sys_wr_ptr, sys_rd_ptr, nrm_wr_ptr, nrm_rd_ptr;
  logic [LW-1:0] sys_cnt, nrm_cnt;
  logic          sys_ne, nrm_ne, sys_wr, nrm_wr, sys_pop, nrm_pop;
  logic          pop_ok, load, grant_sys, vld_p1;
  types::flit_t  head_p0, flit_p1;
  state_t        state, state_nxt;

  function automatic logic [LW-1:0] next_cnt(input logic [LW-1:0] c, input logic w, input logic r);
    case ({w, r})
      2'b10:   return c + LW'(1);
      2'b01:   return c - LW'(1);
      default: return c;
    endcase
  endfunction

  always_comb begin
    out_stall = (sys_cnt == FULL_CNT) | (nrm_cnt == FULL_CNT);
    sys_ne    = (sys_cnt != '0);
    nrm_ne    = (nrm_cnt != '0);
    sys_wr    = in_sys_flit_valid & ~out_stall;
    nrm_wr    = in_normal_flit_valid & ~out_stall;
    pop_ok    = (state == ST_EMPTY) | in_flit_ready;
    load      = pop_ok & (sys_ne | nrm_ne);
    sys_pop   = load & grant_sys;
    nrm_pop   = load & ~grant_sys;
    head_p0   = grant_sys ? sys_mem_p0[sys_rd_ptr] : nrm_mem_p0[nrm_rd_ptr];
  end

`ifdef STAGE40_ROUND_ROBIN_EN
  // Points at the class favoured by the next contested pop; reset favours sys.
  logic rr_nrm_next;

  always_comb grant_sys = sys_ne & (~nrm_ne | ~rr_nrm_next);

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst)
      rr_nrm_next <= 1'b0;
    else if (load && sys_ne && nrm_ne)
      rr_nrm_next <= grant_sys;
  end
`else
  always_comb grant_sys = sys_ne;
`endif

  // Stage p0: class FIFO storage and control
  always_ff @(posedge nocclk) begin
    if (sys_wr) sys_mem_p0[sys_wr_ptr] <= in_sys_flit;
    if (nrm_wr) nrm_mem_p0[nrm_wr_ptr] <= in_normal_flit;
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      sys_wr_ptr <= '0;
      sys_rd_ptr <= '0;
      nrm_wr_ptr <= '0;
      nrm_rd_ptr <= '0;
      sys_cnt    <= '0;
      nrm_cnt    <= '0;
    end else begin
      if (sys_wr)  sys_wr_ptr <= sys_wr_ptr + PW'(1);
      if (sys_pop) sys_rd_ptr <= sys_rd_ptr + PW'(1);
      if (nrm_wr)  nrm_wr_ptr <= nrm_wr_ptr + PW'(1);
      if (nrm_pop) nrm_rd_ptr <= nrm_rd_ptr + PW'(1);
      sys_cnt <= next_cnt(sys_cnt, sys_wr, sys_pop);
      nrm_cnt <= next_cnt(nrm_cnt, nrm_wr, nrm_pop);
    end
  end

  // Stage p1: output register state machine
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pop_ok)
      state_nxt = (sys_ne | nrm_ne) ? ST_FULL : ST_EMPTY;
  end

  always_comb begin
    vld_p1 = (state == ST_FULL);
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst)
      flit_p1 <= '0;
    else if (load)
      flit_p1 <= head_p0;
  end

  assign out_flit_valid   = vld_p1;
  assign out_flit         = flit_p1;
  assign out_sys_level    = sys_cnt;
  assign out_normal_level = nrm_cnt;

endmodule

// File: tb/tb_stage40.sv
// Bench for stage40: directed scenarios plus random traffic, checked each cycle against a queue-based model.
module tb_stage40;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          nocclk = 1'b0;
  logic          rst;
  logic          in_sys_flit_valid, in_normal_flit_valid, in_flit_ready;
  types::flit_t  in_sys_flit, in_normal_flit, out_flit;
  logic          out_stall, out_flit_valid;
  logic [LW-1:0] out_sys_level, out_normal_level;

  stage40 #(.FIFO_DEPTH(D)) dut (
    .nocclk(nocclk), .rst(rst),
    .in_sys_flit_valid(in_sys_flit_valid), .in_sys_flit(in_sys_flit),
    .in_normal_flit_valid(in_normal_flit_valid), .in_normal_flit(in_normal_flit),
    .out_stall(out_stall), .out_flit_valid(out_flit_valid), .out_flit(out_flit),
    .in_flit_ready(in_flit_ready),
    .out_sys_level(out_sys_level), .out_normal_level(out_normal_level)
  );

  always #5 nocclk = ~nocclk;

  int checks = 0;
  int failures = 0;

  types::flit_t sq[$], nq[$], got[$];
  bit           mv;
  types::flit_t md;
  bit           rr_sys_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    nq.delete();
    mv = 1'b0;
    md = '0;
    rr_sys_next = 1'b1;
  endtask

  // Transaction-level view of one clock edge: pop from pre-edge queues, then accept inputs.
  task automatic model_edge(input bit sv, input types::flit_t sf, input bit nv, input types::flit_t nf, input bit rdy);
    bit st;
    bit s;
    bit n;
    bit take_sys;
    st = (sq.size() == D) || (nq.size() == D);
    if (!mv || rdy) begin
      s = (sq.size() != 0);
      n = (nq.size() != 0);
      if (s || n) begin
        take_sys = s;
`ifdef STAGE40_ROUND_ROBIN_EN
        if (s && n) begin
          take_sys = rr_sys_next;
          rr_sys_next = !take_sys;
        end
`endif
        md = take_sys ? sq.pop_front() : nq.pop_front();
        mv = 1'b1;
      end else begin
        mv = 1'b0;
      end
    end
    if (!st) begin
      if (sv) sq.push_back(sf);
      if (nv) nq.push_back(nf);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(out_flit_valid), 32'(mv));
    chk({tag, ".flit"}, 32'(out_flit), 32'(md));
    chk({tag, ".sys_level"}, 32'(out_sys_level), sq.size());
    chk({tag, ".normal_level"}, 32'(out_normal_level), nq.size());
    chk({tag, ".stall"}, 32'(out_stall), 32'((sq.size() == D) || (nq.size() == D)));
  endtask

  task automatic step(input string tag, input bit sv, input types::flit_t sf, input bit nv, input types::flit_t nf, input bit rdy);
    in_sys_flit_valid    = sv;
    in_sys_flit          = sf;
    in_normal_flit_valid = nv;
    in_normal_flit       = nf;
    in_flit_ready        = rdy;
    if (out_flit_valid && rdy) got.push_back(out_flit);
    @(posedge nocclk);
    model_edge(sv, sf, nv, nf, rdy);
    #1;
    compare_all(tag);
  endtask

  task automatic pulse_reset();
    @(negedge nocclk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.valid_now", 32'(out_flit_valid), 32'd0);
    chk("rst.sys_level_now", 32'(out_sys_level), 32'd0);
    chk("rst.normal_level_now", 32'(out_normal_level), 32'd0);
    chk("rst.stall_now", 32'(out_stall), 32'd0);
    @(posedge nocclk);
    @(negedge nocclk);
    rst = 1'b0;
  endtask

  initial begin
    types::flit_t exp_order[4];
    bit sv, nv, rdy;
    types::flit_t sf, nf;
    int idx;

    rst = 1'b1;
    in_sys_flit_valid = 1'b0;
    in_normal_flit_valid = 1'b0;
    in_sys_flit = '0;
    in_normal_flit = '0;
    in_flit_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge nocclk);
    #1;
    compare_all("reset");
    @(negedge nocclk);
    rst = 1'b0;

    // Single normal flit, two-cycle latency, one-cycle valid
    step("single0", 0, '0, 1, 16'h005A, 1);
    chk("single.valid_after_e0", 32'(out_flit_valid), 32'd0);
    step("single1", 0, '0, 0, '0, 1);
    chk("single.flit", 32'(out_flit), 32'h5A);
    chk("single.valid_after_e1", 32'(out_flit_valid), 32'd1);
    step("single2", 0, '0, 0, '0, 1);
    chk("single.valid_after_e2", 32'(out_flit_valid), 32'd0);

    // Simultaneous sys A and normal B
    step("ab0", 1, 16'h00A0, 1, 16'h00B0, 1);
    step("ab1", 0, '0, 0, '0, 1);
    chk("ab.first", 32'(out_flit), 32'hA0);
    step("ab2", 0, '0, 0, '0, 1);
    chk("ab.second", 32'(out_flit), 32'hB0);
    step("ab3", 0, '0, 0, '0, 1);

    // Fill sys FIFO with ready low, hold a 6th flit, then drain
    got.delete();
    for (int i = 0; i < 5; i++) step("fill", 1, 16'h0100 + 16'(i), 0, '0, 0);
    chk("fill.stall", 32'(out_stall), 32'd1);
    chk("fill.sys_level", 32'(out_sys_level), 32'd4);
    step("held", 1, 16'h0105, 0, '0, 0);
    chk("held.sys_level", 32'(out_sys_level), 32'd4);
    step("unstall", 1, 16'h0105, 0, '0, 1);
    chk("unstall.stall", 32'(out_stall), 32'd0);
    step("write6", 1, 16'h0105, 0, '0, 1);
    for (int i = 0; i < 8; i++) step("drain", 0, '0, 0, '0, 1);
    chk("fill.count", got.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk("fill.order", 32'(got[i]), 32'h100 + 32'(i));

    // Contested classes from a fresh reset
    pulse_reset();
    got.delete();
    for (int i = 0; i < 6; i++) step("contest", 1, 16'h0200 + 16'(i), 1, 16'h0300 + 16'(i), 1);
    for (int i = 0; i < 16; i++) step("contest_drain", 0, '0, 0, '0, 1);
`ifdef STAGE40_ROUND_ROBIN_EN
    exp_order = '{16'h0200, 16'h0300, 16'h0201, 16'h0301};
`else
    exp_order = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
`endif
    chk("contest.enough", 32'(got.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("contest.order", 32'(got[i]), 32'(exp_order[i]));

    // Ready toggling under a normal stream that holds while stalled
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (!out_stall && i < 12) begin
        nf = 16'h0400 + 16'(idx);
        idx++;
        step("toggle", 0, '0, 1, nf, (i % 2) == 0);
      end else begin
        step("toggle", 0, '0, i < 12, nf, (i % 2) == 0);
      end
    end
    for (int i = 0; i < 10; i++) step("toggle_drain", 0, '0, 0, '0, 1);

    // Random traffic
    sv = 0; nv = 0; sf = '0; nf = '0;
    for (int i = 0; i < 400; i++) begin
      if (!out_stall) begin
        sv = ($urandom_range(0, 2) == 0);
        nv = ($urandom_range(0, 1) == 0);
        sf = 16'($urandom);
        nf = 16'($urandom);
      end
      rdy = ($urandom_range(0, 3) != 0);
      step("rand", sv, sf, nv, nf, rdy);
    end

    // Reset while three flits are buffered
    for (int i = 0; i < 3; i++) step("prerst", 1, 16'h0600 + 16'(i), 0, '0, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step("postrst", 0, '0, 0, '0, 1);
      chk("postrst.valid", 32'(out_flit_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
